writeback_stage: RTL and testbench

Final (WB) stage of the 5-stage MIPS pipeline, directly downstream of the memory stage. Consumes the MEM/WB pipeline signals, aligns and extends load data, drives the register-file write port back into decode, and holds a one-entry bypass register so decode can pick up the value committed in the previous cycle. Also detects misaligned loads, keeps a sticky error flag, and optionally counts retired register writes.

---
 rtl/writeback_stage_if.sv | 38 +++
 rtl/writeback_stage.sv | 105 ++++++++++
 tb/tb_writeback_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// MEM/WB pipeline bundle plus register-file write port, bypass and error outputs.
// The retire_cnt member exists only when WB_RETIRE_CNT_EN is defined.
interface writeback_stage_if;
  logic [1:0]  WB_ctlwb;
  logic [31:0] WB_rdata;
  logic [31:0] WB_alu_out;
  logic [4:0]  WB_rd;
  logic [1:0]  WB_ldsize;
  logic        WB_ldsigned;
  logic        err_clr;
  logic        WB_wen;
  logic [31:0] WB_wdata;
  logic [4:0]  WB_wrd;
  logic        FWD_valid;
  logic [4:0]  FWD_rd;
  logic [31:0] FWD_data;
  logic        WB_misalign;
  logic        err_sticky;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  modport master (
    output WB_ctlwb, WB_rdata, WB_alu_out, WB_rd, WB_ldsize, WB_ldsigned, err_clr,
    input  WB_wen, WB_wdata, WB_wrd, FWD_valid, FWD_rd, FWD_data, WB_misalign, err_sticky
`ifdef WB_RETIRE_CNT_EN
    , input retire_cnt
`endif
  );

  modport slave (
    input  WB_ctlwb, WB_rdata, WB_alu_out, WB_rd, WB_ldsize, WB_ldsigned, err_clr,
    output WB_wen, WB_wdata, WB_wrd, FWD_valid, FWD_rd, FWD_data, WB_misalign, err_sticky
`ifdef WB_RETIRE_CNT_EN
    , output retire_cnt
`endif
  );
endinterface

// File: rtl/writeback_stage.sv
// MIPS writeback stage: big-endian load alignment/extension, regfile write port,
// one-entry bypass register, sticky misalign flag. WB_RETIRE_CNT_EN adds a retire counter.
module writeback_stage (
  input logic              clk,
  input logic              rst,
  writeback_stage_if.slave wb
);

  logic        reg_write;
  logic        mem_to_reg;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] wdata;
  logic        is_half;
  logic        is_word;
  logic        misalign;
  logic        commit;

  logic        fwd_valid_q;
  logic [4:0]  fwd_rd_q;
  logic [31:0] fwd_data_q;
  logic        err_q;

  assign reg_write  = wb.WB_ctlwb[1];
  assign mem_to_reg = wb.WB_ctlwb[0];
  assign off        = wb.WB_alu_out[1:0];
  assign is_half    = (wb.WB_ldsize == 2'b01);
  assign is_word    = (wb.WB_ldsize == 2'b00) || (wb.WB_ldsize == 2'b11);

  // Big-endian: offset 0 addresses the most significant byte of the word
  always_comb begin
    ld_byte = 8'h00;
    case (off)
      2'd0: ld_byte = wb.WB_rdata[31:24];
      2'd1: ld_byte = wb.WB_rdata[23:16];
      2'd2: ld_byte = wb.WB_rdata[15:8];
      2'd3: ld_byte = wb.WB_rdata[7:0];
      default: ld_byte = 8'h00;
    endcase
  end

  assign ld_half = off[1] ? wb.WB_rdata[15:0] : wb.WB_rdata[31:16];

  always_comb begin
    ld_data = wb.WB_rdata;
    if (wb.WB_ldsize == 2'b10) begin
      ld_data = wb.WB_ldsigned ? {{24{ld_byte[7]}}, ld_byte} : {24'h000000, ld_byte};
    end else if (is_half) begin
      ld_data = wb.WB_ldsigned ? {{16{ld_half[15]}}, ld_half} : {16'h0000, ld_half};
    end
  end

  assign wdata    = mem_to_reg ? ld_data : wb.WB_alu_out;
  assign misalign = reg_write & mem_to_reg &
                    ((is_half & off[0]) | (is_word & (off != 2'b00)));
  assign commit   = reg_write & ~misalign & (wb.WB_rd != 5'd0);

  assign wb.WB_wen      = commit;
  assign wb.WB_wdata    = wdata;
  assign wb.WB_wrd      = wb.WB_rd;
  assign wb.WB_misalign = misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= 5'd0;
      fwd_data_q  <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      fwd_valid_q <= commit;
      if (commit) begin
        fwd_rd_q   <= wb.WB_rd;
        fwd_data_q <= wdata;
      end
      // A new misalign outranks a clear issued in the same cycle
      if (misalign) begin
        err_q <= 1'b1;
      end else if (wb.err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign wb.FWD_valid  = fwd_valid_q;
  assign wb.FWD_rd     = fwd_rd_q;
  assign wb.FWD_data   = fwd_data_q;
  assign wb.err_sticky = err_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_q <= 32'h0;
    end else if (commit) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign wb.retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage; counter checks compile in with WB_RETIRE_CNT_EN.
module tb_writeback_stage;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic pend_commit;
  logic [31:0] exp_cnt;

  writeback_stage_if wbif ();

  writeback_stage dut (
    .clk (clk),
    .rst (rst),
    .wb  (wbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [1:0] ctlwb, input logic [31:0] rdata,
                       input logic [31:0] alu, input logic [4:0] rd,
                       input logic [1:0] ldsize, input logic ldsigned,
                       input logic clr, input logic exp_commit);
    wbif.WB_ctlwb    = ctlwb;
    wbif.WB_rdata    = rdata;
    wbif.WB_alu_out  = alu;
    wbif.WB_rd       = rd;
    wbif.WB_ldsize   = ldsize;
    wbif.WB_ldsigned = ldsigned;
    wbif.err_clr     = clr;
    pend_commit      = exp_commit;
    #1;
  endtask

  task automatic idle();
    apply(2'b00, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    if (pend_commit) exp_cnt = exp_cnt + 32'd1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    exp_cnt = 32'h0;
    rst = 1'b1;
    idle();
    #1;
    check("rst_fwd_valid", wbif.FWD_valid, 1'b0);
    check("rst_fwd_rd", wbif.FWD_rd, 5'd0);
    check("rst_fwd_data", wbif.FWD_data, 32'h0);
    check("rst_err", wbif.err_sticky, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ALU write and bypass timing
    apply(2'b10, 32'h0, 32'h12345678, 5'd5, 2'b00, 1'b0, 1'b0, 1'b1);
    check("alu_wen", wbif.WB_wen, 1'b1);
    check("alu_wdata", wbif.WB_wdata, 32'h12345678);
    check("alu_wrd", wbif.WB_wrd, 5'd5);
    step();
    idle();
    check("alu_fwd_valid", wbif.FWD_valid, 1'b1);
    check("alu_fwd_rd", wbif.FWD_rd, 5'd5);
    check("alu_fwd_data", wbif.FWD_data, 32'h12345678);
    step();
    check("idle_fwd_valid", wbif.FWD_valid, 1'b0);
    check("idle_fwd_rd_hold", wbif.FWD_rd, 5'd5);
    check("idle_fwd_data_hold", wbif.FWD_data, 32'h12345678);

    // Load extraction on 0x80FF7F01
    apply(2'b11, 32'h80FF7F01, 32'h00000101, 5'd3, 2'b10, 1'b1, 1'b0, 1'b1);
    check("lb_off1_s", wbif.WB_wdata, 32'hFFFFFFFF);
    check("lb_off1_wen", wbif.WB_wen, 1'b1);
    step();
    apply(2'b11, 32'h80FF7F01, 32'h00000103, 5'd3, 2'b10, 1'b0, 1'b0, 1'b1);
    check("lb_off3_u", wbif.WB_wdata, 32'h00000001);
    step();
    apply(2'b11, 32'h80FF7F01, 32'h00000100, 5'd3, 2'b10, 1'b0, 1'b0, 1'b1);
    check("lb_off0_u", wbif.WB_wdata, 32'h00000080);
    step();
    apply(2'b11, 32'h80FF7F01, 32'h00000102, 5'd3, 2'b10, 1'b1, 1'b0, 1'b1);
    check("lb_off2_s", wbif.WB_wdata, 32'h0000007F);
    step();
    apply(2'b11, 32'h80FF7F01, 32'h00000100, 5'd3, 2'b01, 1'b1, 1'b0, 1'b1);
    check("lh_off0_s", wbif.WB_wdata, 32'hFFFF80FF);
    check("lh_off0_mis", wbif.WB_misalign, 1'b0);
    step();
    apply(2'b11, 32'h80FF7F01, 32'h00000102, 5'd3, 2'b01, 1'b0, 1'b0, 1'b1);
    check("lh_off2_u", wbif.WB_wdata, 32'h00007F01);
    step();
    apply(2'b11, 32'h80FF7F01, 32'h00000100, 5'd3, 2'b00, 1'b1, 1'b0, 1'b1);
    check("lw", wbif.WB_wdata, 32'h80FF7F01);
    step();
    apply(2'b11, 32'h80FF7F01, 32'h00000100, 5'd7, 2'b11, 1'b1, 1'b0, 1'b1);
    check("lw_size11", wbif.WB_wdata, 32'h80FF7F01);
    step();
    check("lw_fwd_rd", wbif.FWD_rd, 5'd7);
    check("lw_fwd_data", wbif.FWD_data, 32'h80FF7F01);

    // $0 suppression
    apply(2'b10, 32'h0, 32'hDEADBEEF, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("r0_wen", wbif.WB_wen, 1'b0);
    step();
    check("r0_fwd_valid", wbif.FWD_valid, 1'b0);
    check("r0_fwd_data_hold", wbif.FWD_data, 32'h80FF7F01);
`ifdef WB_RETIRE_CNT_EN
    check("r0_cnt", wbif.retire_cnt, exp_cnt);
`endif

    // MemtoReg=0 never flags misalign; RegWrite=0 never flags either
    apply(2'b10, 32'h0, 32'h00001001, 5'd4, 2'b01, 1'b0, 1'b0, 1'b1);
    check("alu_odd_mis", wbif.WB_misalign, 1'b0);
    check("alu_odd_wdata", wbif.WB_wdata, 32'h00001001);
    step();
    apply(2'b01, 32'h0, 32'h00001001, 5'd4, 2'b01, 1'b0, 1'b0, 1'b0);
    check("norw_mis", wbif.WB_misalign, 1'b0);
    check("norw_wen", wbif.WB_wen, 1'b0);
    step();

    // Misalign and sticky error
    apply(2'b11, 32'h0, 32'h00001002, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0);
    check("lw_off2_mis", wbif.WB_misalign, 1'b1);
    apply(2'b11, 32'h0, 32'h00001001, 5'd3, 2'b01, 1'b0, 1'b0, 1'b0);
    check("lh_off1_mis", wbif.WB_misalign, 1'b1);
    check("lh_off1_wen", wbif.WB_wen, 1'b0);
    step();
    check("mis_err", wbif.err_sticky, 1'b1);
    check("mis_fwd_valid", wbif.FWD_valid, 1'b0);
    apply(2'b11, 32'h0, 32'h00001001, 5'd3, 2'b01, 1'b0, 1'b1, 1'b0);
    step();
    check("set_beats_clr", wbif.err_sticky, 1'b1);
    apply(2'b00, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    check("clr_err", wbif.err_sticky, 1'b0);
    idle();

`ifdef WB_RETIRE_CNT_EN
    force dut.retire_q = 32'hFFFFFFFE;
    #1;
    release dut.retire_q;
    exp_cnt = 32'hFFFFFFFE;
    apply(2'b10, 32'h0, 32'h00000011, 5'd9, 2'b00, 1'b0, 1'b0, 1'b1);
    step();
    check("cnt_max", wbif.retire_cnt, 32'hFFFFFFFF);
    step();
    check("cnt_wrap", wbif.retire_cnt, 32'h00000000);
    idle();
    step();
`endif

    // Reset mid-operation with err_sticky set and three commits in flight
    apply(2'b11, 32'h0, 32'h00000003, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    apply(2'b10, 32'h0, 32'h00000021, 5'd2, 2'b00, 1'b0, 1'b0, 1'b1);
    step();
    step();
    step();
    check("pre_rst_err", wbif.err_sticky, 1'b1);
    check("pre_rst_fwd_valid", wbif.FWD_valid, 1'b1);
    #2;
    rst = 1'b1;
    exp_cnt = 32'h0;
    #1;
    check("mid_rst_fwd_valid", wbif.FWD_valid, 1'b0);
    check("mid_rst_fwd_data", wbif.FWD_data, 32'h0);
    check("mid_rst_err", wbif.err_sticky, 1'b0);
    check("mid_rst_wen_comb", wbif.WB_wen, 1'b1);
`ifdef WB_RETIRE_CNT_EN
    check("mid_rst_cnt", wbif.retire_cnt, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    apply(2'b10, 32'h0, 32'h00000055, 5'd6, 2'b00, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    check("post_rst_fwd_valid", wbif.FWD_valid, 1'b1);
    check("post_rst_fwd_data", wbif.FWD_data, 32'h00000055);
`ifdef WB_RETIRE_CNT_EN
    check("post_rst_cnt", wbif.retire_cnt, 32'h1);
`endif
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
